// File: rtl/pulse_gen.sv
// Programmable pulse-train transmitter: num pulses of hi_len cycles separated by lo_len low cycles.
// Optional pulse counter output enabled by defining PULSE_GEN_CNT_EN.
module pulse_gen #(
  parameter int LEN_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] hi_len,
  input  logic [LEN_W-1:0] lo_len,
  input  logic [NUM_W-1:0] num,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
`ifdef PULSE_GEN_CNT_EN
  output logic [NUM_W-1:0] pulse_cnt,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  state_e           state_q;
  logic [LEN_W-1:0] hi_q;
  logic [LEN_W-1:0] lo_q;
  logic [LEN_W-1:0] len_cnt_q;
  logic [NUM_W-1:0] rem_q;
  logic [LEN_W-1:0] hi_eff;
  logic [LEN_W-1:0] lo_eff;

  // A zero length is treated as a one-cycle phase.
  assign hi_eff    = (hi_len == '0) ? LEN_ONE : hi_len;
  assign lo_eff    = (lo_len == '0) ? LEN_ONE : lo_len;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      len_cnt_q <= '0;
      rem_q     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PULSE_GEN_CNT_EN
      pulse_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state_q   <= S_IDLE;
        pulse_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (num == '0) begin
                done <= 1'b1;
              end else begin
                hi_q      <= hi_eff;
                lo_q      <= lo_eff;
                rem_q     <= num;
                len_cnt_q <= hi_eff - LEN_ONE;
                state_q   <= S_HIGH;
                pulse_out <= 1'b1;
                busy      <= 1'b1;
`ifdef PULSE_GEN_CNT_EN
                // Clear and count the first rising edge in one step.
                pulse_cnt <= NUM_ONE;
`endif
              end
            end
          end
          S_HIGH: begin
            if (len_cnt_q != '0) begin
              len_cnt_q <= len_cnt_q - LEN_ONE;
            end else if (rem_q <= NUM_ONE) begin
              // Last pulse: no trailing low gap, straight to done.
              rem_q     <= '0;
              state_q   <= S_IDLE;
              pulse_out <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              rem_q     <= rem_q - NUM_ONE;
              len_cnt_q <= lo_q - LEN_ONE;
              state_q   <= S_LOW;
              pulse_out <= 1'b0;
            end
          end
          S_LOW: begin
            if (len_cnt_q != '0) begin
              len_cnt_q <= len_cnt_q - LEN_ONE;
            end else begin
              len_cnt_q <= hi_q - LEN_ONE;
              state_q   <= S_HIGH;
              pulse_out <= 1'b1;
`ifdef PULSE_GEN_CNT_EN
              pulse_cnt <= pulse_cnt + NUM_ONE;
`endif
            end
          end
          default: begin
            state_q   <= S_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: a waveform-list reference model checked every cycle, plus literal
// expectations for the directed bursts. Handshake: start is taken only when idle; abort wins.
module tb_pulse_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] hi_len;
  logic [7:0] lo_len;
  logic [7:0] num;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;
`ifdef PULSE_GEN_CNT_EN
  logic [7:0] pulse_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  pulse_gen #(.LEN_W(8), .NUM_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .hi_len    (hi_len),
    .lo_len    (lo_len),
    .num       (num),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
`ifdef PULSE_GEN_CNT_EN
    .pulse_cnt (pulse_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted start expands into the full list of per-cycle outputs.
  typedef struct packed {
    logic       p;
    logic       b;
    logic       d;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic [7:0] m_cnt;

  function automatic exp_t mk(logic p, logic b, logic d, logic [7:0] c);
    exp_t e;
    e.p = p;
    e.b = b;
    e.d = d;
    e.c = c;
    return e;
  endfunction

  task automatic build_train(int h_in, int l_in, int n);
    int h, l, t, ph;
    logic [7:0] c;
    h = (h_in == 0) ? 1 : h_in;
    l = (l_in == 0) ? 1 : l_in;
    t = n * h + (n - 1) * l;
    c = 8'd0;
    for (int j = 0; j < t; j++) begin
      ph = j % (h + l);
      if (ph == 0) c = c + 8'd1;
      exp_q.push_back(mk(ph < h, 1'b1, 1'b0, c));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, c));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 8'd0;
      cur = mk(1'b0, 1'b0, 1'b0, 8'd0);
    end else if (abort) begin
      exp_q.delete();
      cur = mk(1'b0, 1'b0, 1'b0, m_cnt);
    end else if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      m_cnt = cur.c;
    end else if (start && num == 8'd0) begin
      cur = mk(1'b0, 1'b0, 1'b1, m_cnt);
    end else if (start) begin
      build_train(int'(hi_len), int'(lo_len), int'(num));
      cur = exp_q.pop_front();
      m_cnt = cur.c;
    end else begin
      cur = mk(1'b0, 1'b0, 1'b0, m_cnt);
    end
  end

  // Scoreboard compare, every cycle away from the active edge.
  always @(negedge clk) begin
    logic [10:0] act, expv;
`ifdef PULSE_GEN_CNT_EN
    act  = {pulse_out, busy, done, pulse_cnt};
    expv = {cur.p, cur.b, cur.d, cur.c};
`else
    act  = {pulse_out, busy, done, 8'd0};
    expv = {cur.p, cur.b, cur.d, 8'd0};
`endif
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL model_cycle t=%0t: got p/b/d/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
               $time, act[10], act[9], act[8], act[7:0], expv[10], expv[9], expv[8], expv[7:0]);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Driver tasks: called at a falling edge; return at the falling edge after the accept edge.
  task automatic launch(int h, int l, int n);
    hi_len = 8'(h);
    lo_len = 8'(l);
    num    = 8'(n);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic idle_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] pat;
  logic [7:0] dpat;
  logic       all_busy;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    hi_len = 8'd0;
    lo_len = 8'd0;
    num    = 8'd0;
    idle_cycles(3);
    chk("reset_outputs", 32'({pulse_out, busy, done}), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // num=3, hi=2, lo=1
    launch(2, 1, 3);
    pat = '0;
    all_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], pulse_out};
      all_busy = all_busy & busy;
      @(negedge clk);
    end
    chk("t1_pattern", 32'(pat), 32'h000000DB);
    chk("t1_busy8", 32'(all_busy), 32'd1);
    chk("t1_done_cycle9", 32'({pulse_out, busy, done}), 32'd1);
`ifdef PULSE_GEN_CNT_EN
    chk("t1_pulse_cnt", 32'(pulse_cnt), 32'd3);
`endif
    @(negedge clk);
    chk("t1_done_drop", 32'(done), 32'd0);
    idle_cycles(2);

    // zero lengths treated as one
    launch(0, 0, 2);
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      pat = {pat[6:0], pulse_out};
      @(negedge clk);
    end
    chk("t2_pattern", 32'(pat), 32'd5);
    chk("t2_done", 32'({pulse_out, busy, done}), 32'd1);
    idle_cycles(2);

    // num=0
    launch(3, 3, 0);
    chk("t3_done_only", 32'({pulse_out, busy, done}), 32'd1);
    @(negedge clk);
    chk("t3_done_drop", 32'({pulse_out, busy, done}), 32'd0);
    idle_cycles(2);

    // abort during the second pulse, with an ignored start mid-train
    launch(3, 2, 4);
    idle_cycles(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(2);
    chk("t4_second_pulse_high", 32'(pulse_out), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_outputs", 32'({pulse_out, busy, done}), 32'd0);
    dpat = '0;
    for (int i = 0; i < 6; i++) begin
      dpat = dpat | {7'd0, done};
      @(negedge clk);
    end
    chk("t4_no_done", 32'(dpat), 32'd0);
`ifdef PULSE_GEN_CNT_EN
    chk("t4_cnt_hold", 32'(pulse_cnt), 32'd2);
`endif

    // start held high: back-to-back single pulses
    hi_len = 8'd2;
    lo_len = 8'd1;
    num    = 8'd1;
    start  = 1'b1;
    @(negedge clk);
    pat = '0;
    dpat = '0;
    for (int i = 0; i < 6; i++) begin
      pat  = {pat[6:0], pulse_out};
      dpat = {dpat[6:0], done};
      @(negedge clk);
    end
    start = 1'b0;
    chk("t5_pattern", 32'(pat), 32'h00000036);
    chk("t5_done_pattern", 32'(dpat), 32'h00000009);
    idle_cycles(5);

    // async reset mid-train, then retrigger
    launch(4, 3, 3);
    idle_cycles(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", 32'({pulse_out, busy, done}), 32'd0);
`ifdef PULSE_GEN_CNT_EN
    chk("t6_cnt_reset", 32'(pulse_cnt), 32'd0);
`endif
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    launch(1, 1, 2);
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      pat = {pat[6:0], pulse_out};
      @(negedge clk);
    end
    chk("t6_retrigger", 32'(pat), 32'd5);
    chk("t6_retrigger_done", 32'(done), 32'd1);
    idle_cycles(2);

    // randomized stimulus; inputs change every cycle, including mid-train
    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 60) == 0);
      hi_len = 8'($urandom_range(0, 4));
      lo_len = 8'($urandom_range(0, 4));
      num    = 8'($urandom_range(0, 4));
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    idle_cycles(40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
